sgfm_left_normalizer: RTL and testbench

- Pipelined left-shift normalizer for the floating-point datapath.
- Sits after the significand add/subtract stage, on the opposite side of the right-shift alignment stage.
- Counts leading zeros of the unnormalized significand, shifts it left until bit W_Sgf+2 is 1, and subtracts the shift amount from the exponent.
- If the exponent cannot absorb the full shift, the shift is clamped at the exponent and underflow is flagged.
- Two register stages with valid/ready flow control.

---
 rtl/sgfm_left_normalizer_pkg.sv | 9 +
 rtl/lzc_param.sv | 22 ++
 rtl/sgfm_left_normalizer.sv | 139 +++++++++++++
 tb/tb_sgfm_left_normalizer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sgfm_left_normalizer_pkg.sv
// Shared helpers for the left normalizer: width of a leading-zero count
// able to represent every value 0..w.
package sgfm_left_normalizer_pkg;

    function automatic int lzc_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lzc_param.sv
// Combinational leading-zero counter; cnt equals W when vec is all zeros.
module lzc_param
    import sgfm_left_normalizer_pkg::*;
#(
    parameter int W = 26,
    localparam int CW = lzc_width(W)
) (
    input  logic [W-1:0]  vec,
    output logic [CW-1:0] cnt
);

    // Scan from the LSB up so the highest set bit is the one that sticks.
    always_comb begin
        cnt = CW'(W);
        for (int i = 0; i < W; i++) begin
            if (vec[i]) begin
                cnt = CW'(W - 1 - i);
            end
        end
    end

endmodule

// File: rtl/sgfm_left_normalizer.sv
// Two-stage left-shift normalizer: S1 registers the operand and its LZC,
// S2 registers the clamped shift, shifted significand and adjusted exponent.
module sgfm_left_normalizer
    import sgfm_left_normalizer_pkg::*;
#(
    parameter int W_Sgf = 23,
    parameter int W_Exp = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [W_Sgf+2:0]   sgfm,
    input  logic [W_Exp-1:0]   exp,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W_Sgf+2:0]   sgfm_n,
    output logic [W_Exp-1:0]   exp_n,
    output logic [W_Exp-1:0]   nshift,
    output logic               zero,
    output logic               uflow
);

    localparam int W_S = W_Sgf + 3;
    localparam int LZW = lzc_width(W_S);

    logic               s1_valid_reg;
    logic [W_S-1:0]     s1_sgfm_reg;
    logic [W_Exp-1:0]   s1_exp_reg;
    logic [LZW-1:0]     s1_lz_reg;

    logic               s2_valid_reg;
    logic [W_S-1:0]     sgfm_n_reg;
    logic [W_Exp-1:0]   exp_n_reg;
    logic [W_Exp-1:0]   nshift_reg;
    logic               zero_reg;
    logic               uflow_reg;

    logic               s2_load;
    logic               s1_load;
    logic [LZW-1:0]     lz_in;

    logic [W_Exp-1:0]   lz_ext;
    logic               s1_zero;
    logic               lz_gt_exp;
    logic [W_Exp-1:0]   sh_next;
    logic [LZW:0][W_S-1:0] shift_stage;

    logic [W_S-1:0]     sgfm_n_next;
    logic [W_Exp-1:0]   exp_n_next;
    logic [W_Exp-1:0]   nshift_next;
    logic               zero_next;
    logic               uflow_next;

    assign s2_load  = !s2_valid_reg || out_ready;
    assign s1_load  = !s1_valid_reg || s2_load;
    assign in_ready = s1_load;

    lzc_param #(.W(W_S)) u_lzc (
        .vec (sgfm),
        .cnt (lz_in)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_sgfm_reg  <= '0;
            s1_exp_reg   <= '0;
            s1_lz_reg    <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_sgfm_reg <= sgfm;
                s1_exp_reg  <= exp;
                s1_lz_reg   <= lz_in;
            end
        end
    end

    assign lz_ext    = W_Exp'(s1_lz_reg);
    assign s1_zero   = (s1_sgfm_reg == '0);
    assign lz_gt_exp = (lz_ext > s1_exp_reg);
    assign sh_next   = lz_gt_exp ? s1_exp_reg : lz_ext;

    // For nonzero operands sh <= lz < 2**LZW, so the low LZW bits fully
    // describe the shift; the zero case is forced to 0 below.
    assign shift_stage[0] = s1_sgfm_reg;
    generate
        for (genvar gi = 0; gi < LZW; gi++) begin : g_shift
            assign shift_stage[gi+1] = sh_next[gi] ? (shift_stage[gi] << (1 << gi))
                                                   : shift_stage[gi];
        end
    endgenerate

    always_comb begin
        sgfm_n_next = '0;
        exp_n_next  = '0;
        nshift_next = '0;
        zero_next   = 1'b1;
        uflow_next  = 1'b0;
        if (!s1_zero) begin
            sgfm_n_next = shift_stage[LZW];
            exp_n_next  = s1_exp_reg - sh_next;
            nshift_next = sh_next;
            zero_next   = 1'b0;
            uflow_next  = lz_gt_exp;
        end
    end

    // Data registers only move when a real word arrives, keeping outputs
    // stable under backpressure and across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            sgfm_n_reg   <= '0;
            exp_n_reg    <= '0;
            nshift_reg   <= '0;
            zero_reg     <= 1'b0;
            uflow_reg    <= 1'b0;
        end else if (s2_load) begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                sgfm_n_reg <= sgfm_n_next;
                exp_n_reg  <= exp_n_next;
                nshift_reg <= nshift_next;
                zero_reg   <= zero_next;
                uflow_reg  <= uflow_next;
            end
        end
    end

    assign out_valid = s2_valid_reg;
    assign sgfm_n    = sgfm_n_reg;
    assign exp_n     = exp_n_reg;
    assign nshift    = nshift_reg;
    assign zero      = zero_reg;
    assign uflow     = uflow_reg;

endmodule

// File: tb/tb_sgfm_left_normalizer.sv
// Self-checking bench: directed table, backpressure and reset sequences,
// and a random sweep scored against a plain-arithmetic reference model.
module tb_sgfm_left_normalizer;

    localparam int WS = 26;
    localparam int WE = 8;

    typedef struct packed {
        logic [WS-1:0] sgfm_n;
        logic [WE-1:0] exp_n;
        logic [WE-1:0] nshift;
        logic          zero;
        logic          uflow;
    } res_t;

    typedef struct {
        logic [WS-1:0] sgfm;
        logic [WE-1:0] exp;
        res_t          want;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [WS-1:0] sgfm;
    logic [WE-1:0] exp;
    logic          out_valid;
    logic          out_ready;
    logic [WS-1:0] sgfm_n;
    logic [WE-1:0] exp_n;
    logic [WE-1:0] nshift;
    logic          zero;
    logic          uflow;

    int   checks = 0;
    int   errors = 0;
    int   popped = 0;
    res_t exp_q[$];
    logic last_acc;
    logic last_valid;
    logic last_in_ready;
    res_t last_res;
    vec_t tbl[10];

    always #5 clk = ~clk;

    sgfm_left_normalizer #(.W_Sgf(23), .W_Exp(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sgfm      (sgfm),
        .exp       (exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sgfm_n    (sgfm_n),
        .exp_n     (exp_n),
        .nshift    (nshift),
        .zero      (zero),
        .uflow     (uflow)
    );

    // Reference: count zeros from the top, shift by the smaller of that
    // count and the exponent.
    function automatic res_t model(input logic [WS-1:0] s, input logic [WE-1:0] e);
        res_t r;
        int   lz;
        int   sh;
        r  = '0;
        lz = 0;
        while (lz < WS && s[WS-1-lz] == 1'b0) lz++;
        if (lz == WS) begin
            r.zero = 1'b1;
        end else begin
            sh       = (lz < int'(e)) ? lz : int'(e);
            r.sgfm_n = s << sh;
            r.exp_n  = WE'(int'(e) - sh);
            r.nshift = WE'(sh);
            r.uflow  = (lz > int'(e));
        end
        return r;
    endfunction

    // One cycle: sample at the falling edge, score, then advance to just
    // after the next rising edge.
    task automatic tick();
        logic want_rdy;
        @(negedge clk);
        last_in_ready = in_ready;
        last_valid    = out_valid;
        last_res      = {sgfm_n, exp_n, nshift, zero, uflow};
        want_rdy      = (exp_q.size() < 2) || out_ready;
        checks++;
        if (in_ready !== want_rdy) begin
            errors++;
            $display("FAIL in_ready got=%b want=%b inflight=%0d", in_ready, want_rdy, exp_q.size());
        end
        if (out_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_out got sgfm_n=%h exp_n=%0d want no output", sgfm_n, exp_n);
            end else begin
                if (last_res !== exp_q[0]) begin
                    errors++;
                    $display("FAIL scoreboard got=%h want=%h", last_res, exp_q[0]);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    popped++;
                end
            end
        end
        last_acc = in_valid && in_ready;
        if (last_acc) exp_q.push_back(model(sgfm, exp));
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string name);
        logic [WS+2*WE+3:0] got;
        logic [WS+2*WE+3:0] want;
        got  = {out_valid, sgfm_n, exp_n, nshift, zero, uflow, in_ready};
        want = {1'b0, {WS{1'b0}}, {WE{1'b0}}, {WE{1'b0}}, 1'b0, 1'b0, 1'b1};
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end else begin
            $display("%s ok: out_valid=0 outputs=0 in_ready=1", name);
        end
    endtask

    task automatic run_vec(input int idx);
        int   lat;
        logic got;
        in_valid  = 1'b1;
        sgfm      = tbl[idx].sgfm;
        exp       = tbl[idx].exp;
        out_ready = 1'b1;
        tick();
        checks++;
        if (!last_acc) begin
            errors++;
            $display("FAIL vec%0d_accept got=0 want=1", idx);
        end
        in_valid = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (last_valid) begin
                got = 1'b1;
                checks++;
                if (last_res !== tbl[idx].want) begin
                    errors++;
                    $display("FAIL vec%0d got=%h want=%h", idx, last_res, tbl[idx].want);
                end else begin
                    $display("vec%0d sgfm=%h exp=%0d -> sgfm_n=%h exp_n=%0d nshift=%0d zero=%b uflow=%b",
                             idx, tbl[idx].sgfm, tbl[idx].exp, last_res.sgfm_n, last_res.exp_n,
                             last_res.nshift, last_res.zero, last_res.uflow);
                end
            end
        end
        checks++;
        if (lat != 2) begin
            errors++;
            $display("FAIL vec%0d_latency got=%0d want=2", idx, lat);
        end
    endtask

    initial begin
        int sent;
        int c;
        int n;
        int cyc;
        int pop0;
        logic stall_seen;

        tbl[0] = '{26'h0800000, 8'd100, '{26'h2000000, 8'd98,  8'd2,  1'b0, 1'b0}};
        tbl[1] = '{26'h0000001, 8'd10,  '{26'h0000400, 8'd0,   8'd10, 1'b0, 1'b1}};
        tbl[2] = '{26'h0800000, 8'd2,   '{26'h2000000, 8'd0,   8'd2,  1'b0, 1'b0}};
        tbl[3] = '{26'h0000000, 8'd77,  '{26'h0000000, 8'd0,   8'd0,  1'b1, 1'b0}};
        tbl[4] = '{26'h2ABCDEF, 8'd5,   '{26'h2ABCDEF, 8'd5,   8'd0,  1'b0, 1'b0}};
        tbl[5] = '{26'h0000001, 8'd200, '{26'h2000000, 8'd175, 8'd25, 1'b0, 1'b0}};
        tbl[6] = '{26'h1000000, 8'd0,   '{26'h1000000, 8'd0,   8'd0,  1'b0, 1'b1}};
        tbl[7] = '{26'h3FFFFFF, 8'd0,   '{26'h3FFFFFF, 8'd0,   8'd0,  1'b0, 1'b0}};
        tbl[8] = '{26'h0000000, 8'd0,   '{26'h0000000, 8'd0,   8'd0,  1'b1, 1'b0}};
        tbl[9] = '{26'h0000003, 8'd30,  '{26'h3000000, 8'd6,   8'd24, 1'b0, 1'b0}};

        rst       = 1'b1;
        in_valid  = 1'b0;
        sgfm      = '0;
        exp       = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset("reset_state");
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(i);

        // Backpressure: six distinct words, downstream stalls cycles 3..5.
        sent = 0;
        c = 0;
        stall_seen = 1'b0;
        pop0 = popped;
        while ((sent < 6 || exp_q.size() > 0) && c < 40) begin
            in_valid  = (sent < 6);
            sgfm      = (26'h0001234 << sent) + 26'(sent);
            exp       = WE'(20 + sent);
            out_ready = !(c >= 3 && c <= 5);
            tick();
            if (last_acc) sent++;
            if (!last_in_ready) stall_seen = 1'b1;
            c++;
        end
        in_valid = 1'b0;
        checks++;
        if (popped - pop0 != 6 || sent != 6) begin
            errors++;
            $display("FAIL backpressure_count got sent=%0d out=%0d want 6/6", sent, popped - pop0);
        end else begin
            $display("backpressure: 6 words in, 6 results out in order");
        end
        checks++;
        if (!stall_seen) begin
            errors++;
            $display("FAIL backpressure_stall got in_ready never low want low while full");
        end

        // Reset with two words in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sgfm      = 26'h0040000;
        exp       = 8'd50;
        tick();
        sgfm      = 26'h0000ABC;
        exp       = 8'd3;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk_reset("reset_midflight");
        exp_q.delete();
        @(posedge clk);
        #1;
        run_vec(0);
        run_vec(1);

        // Random sweep.
        n = 0;
        cyc = 0;
        while (n < 10000 && cyc < 60000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            sgfm     = WS'($urandom) >> $urandom_range(0, 26);
            if ($urandom_range(0, 1) == 0) exp = WE'($urandom_range(0, 30));
            else exp = WE'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_acc) n++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while (exp_q.size() > 0 && c < 10) begin
            tick();
            c++;
        end
        checks++;
        if (n != 10000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_sweep got accepted=%0d pending=%0d want 10000/0", n, exp_q.size());
        end else begin
            $display("random sweep: %0d words in %0d cycles", n, cyc);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
